// File: rtl/wb_pkg.sv
// ----------------------------------------------------------------------------
// wb_pkg
// Shared Wishbone definitions for the SRAM slave slice: bus widths, the
// responder FSM state encoding, transaction counter width and a saturating
// increment helper.
// ----------------------------------------------------------------------------
package wb_pkg;

    localparam int WB_DW   = 32;   // data width
    localparam int WB_AW   = 30;   // word address width
    localparam int WB_SW   = 4;    // byte select width
    localparam int COUNT_W = 16;   // transaction counter width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } wb_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        logic [COUNT_W-1:0] r;
        if (v == {COUNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(COUNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_sram_slave_if.sv
// ----------------------------------------------------------------------------
// wb_sram_slave_if
// Wishbone classic-cycle bus bundle between one master and the SRAM slave.
//   adr    master->slave  word address
//   dat_w  master->slave  write data
//   sel    master->slave  byte lane enables
//   we     master->slave  1 = write, 0 = read
//   cyc    master->slave  bus cycle active
//   stb    master->slave  strobe
//   dat_r  slave->master  read data
//   ack    slave->master  transfer acknowledge
// ----------------------------------------------------------------------------
interface wb_sram_slave_if;
    import wb_pkg::*;

    logic [WB_AW-1:0] adr;
    logic [WB_DW-1:0] dat_w;
    logic [WB_DW-1:0] dat_r;
    logic [WB_SW-1:0] sel;
    logic             we;
    logic             cyc;
    logic             stb;
    logic             ack;

    modport master (
        output adr, dat_w, sel, we, cyc, stb,
        input  dat_r, ack
    );

    modport slave (
        input  adr, dat_w, sel, we, cyc, stb,
        output dat_r, ack
    );

endinterface

// File: rtl/wb_sram_bytemem.sv
// ----------------------------------------------------------------------------
// wb_sram_bytemem
// Single-port 2^DEPTH_LOG2 x 32 word RAM with per-byte write enables and a
// registered read port. Contents are deliberately not reset so the array maps
// onto block RAM.
//   sys_clk  in   clock
//   addr     in   word address (shared by read and write)
//   be       in   byte write enables, be[i] writes bits 8i+7:8i
//   wdata    in   write data
//   rdata    out  registered read data (word at addr on the previous edge)
// ----------------------------------------------------------------------------
module wb_sram_bytemem
    import wb_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  sys_clk,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [WB_SW-1:0]      be,
    input  logic [WB_DW-1:0]      wdata,
    output logic [WB_DW-1:0]      rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WB_DW-1:0] mem_r [0:DEPTH-1];
    logic [WB_DW-1:0] rdata_r;

    // Byte-lane writes and read-before-write registered read of the same word.
    always_ff @(posedge sys_clk) begin
        for (int i = 0; i < WB_SW; i++) begin
            if (be[i]) begin
                mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata_r <= mem_r[addr];
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/wb_sram_slave.sv
// ----------------------------------------------------------------------------
// wb_sram_slave
// Wishbone classic-cycle responder backed by a byte-enabled word memory.
// A request is captured in IDLE, held for WAIT_CYCLES wait states and then
// acknowledged for one cycle, provided the master still strobes. Completed
// reads and writes are counted with saturating 16-bit counters.
//   sys_clk   in   clock, rising edge
//   sys_rst   in   asynchronous active-low reset
//   bus       slave modport of wb_sram_slave_if
//   rd_count  out  completed reads (saturating)
//   wr_count  out  completed writes (saturating)
// Parameters:
//   DEPTH_LOG2   memory is 2^DEPTH_LOG2 words; upper address bits alias
//   WAIT_CYCLES  wait states between capture and ack, 0..15
// ----------------------------------------------------------------------------
module wb_sram_slave
    import wb_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    wb_sram_slave_if.slave      bus,
    output logic [COUNT_W-1:0]  rd_count,
    output logic [COUNT_W-1:0]  wr_count
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    wb_state_e             state_r;
    wb_state_e             state_s;
    logic [3:0]            wait_cnt_r;
    logic [3:0]            wait_cnt_s;
    logic                  capture_s;

    logic [DEPTH_LOG2-1:0] cap_adr_r;
    logic                  cap_we_r;
    logic [WB_SW-1:0]      cap_sel_r;
    logic [WB_DW-1:0]      cap_wdat_r;

    logic                  req_s;
    logic                  acc_ok_s;
    logic                  rd_ack_s;
    logic                  wr_ack_s;

    logic [DEPTH_LOG2-1:0] mem_addr_s;
    logic [WB_SW-1:0]      mem_be_s;
    logic [WB_DW-1:0]      mem_rdata_s;

    logic [COUNT_W-1:0]    rd_count_r;
    logic [COUNT_W-1:0]    wr_count_r;
    logic [WB_DW-1:0]      dat_hold_r;

    logic                  unused_adr_s;

    assign req_s = bus.cyc & bus.stb;

    // The acknowledge must reflect whether the master is still strobing in the
    // ACK cycle itself, so it is the registered ACK state gated by the live
    // request. Reset clears state_r asynchronously, which drops ack at once.
    assign acc_ok_s = (state_r == ACK) & req_s;
    assign rd_ack_s = acc_ok_s & ~cap_we_r;
    assign wr_ack_s = acc_ok_s &  cap_we_r;

    // Upper address bits alias onto the implemented depth.
    assign unused_adr_s = ^bus.adr[WB_AW-1:DEPTH_LOG2];

    // Next-state, capture strobe and wait counter update.
    always_comb begin
        state_s    = state_r;
        wait_cnt_s = wait_cnt_r;
        capture_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    capture_s  = 1'b1;
                    wait_cnt_s = WAIT_INIT;
                    state_s    = (WAIT_INIT == 4'd0) ? ACK : WAIT;
                end else begin
                    state_s    = IDLE;
                end
            end
            WAIT: begin
                if (!req_s) begin
                    // Master withdrew: abandon the access silently.
                    state_s    = IDLE;
                    wait_cnt_s = 4'd0;
                end else if (wait_cnt_r <= 4'd1) begin
                    state_s    = ACK;
                    wait_cnt_s = 4'd0;
                end else begin
                    state_s    = WAIT;
                    wait_cnt_s = wait_cnt_r - 4'd1;
                end
            end
            ACK: begin
                state_s    = IDLE;
                wait_cnt_s = 4'd0;
            end
            default: begin
                state_s    = IDLE;
                wait_cnt_s = 4'd0;
            end
        endcase
    end

    // State and wait counter registers.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_r    <= IDLE;
            wait_cnt_r <= 4'd0;
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
        end
    end

    // Capture of the request; later bus changes are ignored for this access.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            cap_adr_r  <= '0;
            cap_we_r   <= 1'b0;
            cap_sel_r  <= '0;
            cap_wdat_r <= '0;
        end else if (capture_s) begin
            cap_adr_r  <= bus.adr[DEPTH_LOG2-1:0];
            cap_we_r   <= bus.we;
            cap_sel_r  <= bus.sel;
            cap_wdat_r <= bus.dat_w;
        end else begin
            cap_adr_r  <= cap_adr_r;
            cap_we_r   <= cap_we_r;
            cap_sel_r  <= cap_sel_r;
            cap_wdat_r <= cap_wdat_r;
        end
    end

    // Memory port steering. In IDLE the live address is presented so a
    // zero-wait read has its data registered by the ACK cycle; afterwards the
    // captured address keeps the read pointed at the same word, which also
    // covers the last WAIT cycle. Lanes are written only on an acked write.
    always_comb begin
        mem_addr_s = cap_adr_r;
        mem_be_s   = '0;
        if (state_r == IDLE) begin
            mem_addr_s = bus.adr[DEPTH_LOG2-1:0];
        end else begin
            mem_addr_s = cap_adr_r;
        end
        if (wr_ack_s) begin
            mem_be_s = cap_sel_r;
        end else begin
            mem_be_s = '0;
        end
    end

    wb_sram_bytemem #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .sys_clk (sys_clk),
        .addr    (mem_addr_s),
        .be      (mem_be_s),
        .wdata   (cap_wdat_r),
        .rdata   (mem_rdata_s)
    );

    // Saturating transaction counters, bumped on the acknowledging edge.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            rd_count_r <= '0;
            wr_count_r <= '0;
        end else begin
            if (rd_ack_s) begin
                rd_count_r <= sat_inc(rd_count_r);
            end else begin
                rd_count_r <= rd_count_r;
            end
            if (wr_ack_s) begin
                wr_count_r <= sat_inc(wr_count_r);
            end else begin
                wr_count_r <= wr_count_r;
            end
        end
    end

    // Last delivered read word, shown on dat_r whenever no read is acking.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            dat_hold_r <= '0;
        end else if (rd_ack_s) begin
            dat_hold_r <= mem_rdata_s;
        end else begin
            dat_hold_r <= dat_hold_r;
        end
    end

    assign bus.ack   = acc_ok_s;
    assign bus.dat_r = rd_ack_s ? mem_rdata_s : dat_hold_r;
    assign rd_count  = rd_count_r;
    assign wr_count  = wr_count_r;

endmodule

// File: tb/tb_wb_sram_slave.sv
// ----------------------------------------------------------------------------
// tb_wb_sram_slave
// Three slave instances (DEPTH/WAIT = 10/1, 10/3, 4/0) on a shared clock and
// reset. A transaction-level model tracks each slave's expected ack timing,
// memory contents, dat_r and counters; one compare process checks them every
// cycle, and directed sequences add literal expectations.
// ----------------------------------------------------------------------------
module tb_wb_sram_slave;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b0;

    always #5 sys_clk = ~sys_clk;

    wb_sram_slave_if bus_a ();
    wb_sram_slave_if bus_b ();
    wb_sram_slave_if bus_c ();

    logic [29:0] adr_v  [3];
    logic [31:0] datw_v [3];
    logic [3:0]  sel_v  [3];
    logic        we_v   [3];
    logic        cyc_v  [3];
    logic        stb_v  [3];
    logic        ack_v  [3];
    logic [31:0] datr_v [3];
    logic [15:0] rdc_v  [3];
    logic [15:0] wrc_v  [3];

    assign bus_a.adr = adr_v[0]; assign bus_a.dat_w = datw_v[0]; assign bus_a.sel = sel_v[0];
    assign bus_a.we  = we_v[0];  assign bus_a.cyc   = cyc_v[0];  assign bus_a.stb = stb_v[0];
    assign ack_v[0]  = bus_a.ack; assign datr_v[0] = bus_a.dat_r;
    assign bus_b.adr = adr_v[1]; assign bus_b.dat_w = datw_v[1]; assign bus_b.sel = sel_v[1];
    assign bus_b.we  = we_v[1];  assign bus_b.cyc   = cyc_v[1];  assign bus_b.stb = stb_v[1];
    assign ack_v[1]  = bus_b.ack; assign datr_v[1] = bus_b.dat_r;
    assign bus_c.adr = adr_v[2]; assign bus_c.dat_w = datw_v[2]; assign bus_c.sel = sel_v[2];
    assign bus_c.we  = we_v[2];  assign bus_c.cyc   = cyc_v[2];  assign bus_c.stb = stb_v[2];
    assign ack_v[2]  = bus_c.ack; assign datr_v[2] = bus_c.dat_r;

    wb_sram_slave #(.DEPTH_LOG2(10), .WAIT_CYCLES(1)) dut_a (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus_a),
        .rd_count(rdc_v[0]), .wr_count(wrc_v[0]));
    wb_sram_slave #(.DEPTH_LOG2(10), .WAIT_CYCLES(3)) dut_b (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus_b),
        .rd_count(rdc_v[1]), .wr_count(wrc_v[1]));
    wb_sram_slave #(.DEPTH_LOG2(4), .WAIT_CYCLES(0)) dut_c (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus_c),
        .rd_count(rdc_v[2]), .wr_count(wrc_v[2]));

    localparam int W_K    [3] = '{1, 3, 0};
    localparam int MASK_K [3] = '{1023, 1023, 15};

    // ---------------- model state ----------------
    logic [31:0] mem_m   [3][1024];
    bit          known_m [3][1024];
    bit          busy_m  [3];
    bit          pend_m  [3];
    int          age_m   [3];
    bit          cwe_m   [3];
    int          cadr_m  [3];
    logic [3:0]  csel_m  [3];
    logic [31:0] cdat_m  [3];
    logic [31:0] hold_m  [3];
    bit          hkn_m   [3];
    int          rdc_m   [3];
    int          wrc_m   [3];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h (t=%0t)", nm, k, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            busy_m[k] = 1'b0; pend_m[k] = 1'b0; age_m[k] = 0;
            rdc_m[k] = 0; wrc_m[k] = 0; hold_m[k] = 32'h0; hkn_m[k] = 1'b1;
        end
    endtask

    // Compare process: advance the transaction model one cycle and check.
    bit exp_ack_c;
    bit req_c;
    always @(negedge sys_clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!sys_rst) begin
                chk("rst_ack", k, 32'(ack_v[k]), 32'h0);
                chk("rst_datr", k, datr_v[k], 32'h0);
                chk("rst_rdc", k, 32'(rdc_v[k]), 32'h0);
                chk("rst_wrc", k, 32'(wrc_v[k]), 32'h0);
            end else begin
                req_c = cyc_v[k] & stb_v[k];
                exp_ack_c = 1'b0;
                if (busy_m[k]) begin
                    age_m[k]++;
                    if (!req_c) begin
                        busy_m[k] = 1'b0;
                    end else if (age_m[k] == W_K[k] + 1) begin
                        exp_ack_c = 1'b1;
                        busy_m[k] = 1'b0;
                        pend_m[k] = 1'b1;
                    end
                end else if (req_c) begin
                    busy_m[k] = 1'b1; age_m[k] = 0;
                    cwe_m[k]  = we_v[k];
                    cadr_m[k] = int'(adr_v[k]) & MASK_K[k];
                    csel_m[k] = sel_v[k];
                    cdat_m[k] = datw_v[k];
                end
                chk("ack", k, 32'(ack_v[k]), 32'(exp_ack_c));
                if (exp_ack_c && !cwe_m[k]) begin
                    hold_m[k] = mem_m[k][cadr_m[k]];
                    hkn_m[k]  = known_m[k][cadr_m[k]];
                end
                if (hkn_m[k]) chk("dat_r", k, datr_v[k], hold_m[k]);
                chk("rd_count", k, 32'(rdc_v[k]), 32'(rdc_m[k]));
                chk("wr_count", k, 32'(wrc_v[k]), 32'(wrc_m[k]));
            end
        end
    end

    // Model commit on the acknowledging edge.
    always @(posedge sys_clk) begin
        for (int k = 0; k < 3; k++) begin
            if (pend_m[k] && sys_rst) begin
                if (cwe_m[k]) begin
                    for (int i = 0; i < 4; i++)
                        if (csel_m[k][i]) mem_m[k][cadr_m[k]][8*i +: 8] = cdat_m[k][8*i +: 8];
                    if (csel_m[k] == 4'hF) known_m[k][cadr_m[k]] = 1'b1;
                    if (wrc_m[k] < 65535) wrc_m[k]++;
                end else begin
                    if (rdc_m[k] < 65535) rdc_m[k]++;
                end
            end
            pend_m[k] = 1'b0;
        end
    end

    // ---------------- drivers ----------------
    task automatic idle_bus(input int k);
        cyc_v[k] = 1'b0; stb_v[k] = 1'b0; we_v[k] = 1'b0;
        adr_v[k] = 30'h0; sel_v[k] = 4'h0; datw_v[k] = 32'h0;
    endtask

    // One complete access; lat is the cycle of ack counted from the request cycle.
    task automatic access(input int k, input bit w, input logic [29:0] a, input logic [31:0] d,
                          input logic [3:0] s, output int lat, output logic [31:0] rd);
        @(posedge sys_clk); #1;
        cyc_v[k] = 1'b1; stb_v[k] = 1'b1; we_v[k] = w;
        adr_v[k] = a; datw_v[k] = d; sel_v[k] = s;
        lat = -1; rd = 32'h0;
        for (int n = 0; n < 20; n++) begin
            @(negedge sys_clk);
            if (ack_v[k]) begin lat = n; rd = datr_v[k]; break; end
        end
        chk("ack_seen", k, 32'(lat >= 0), 32'h1);
        @(posedge sys_clk); #1;
        idle_bus(k);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before finish");
        $fatal(1);
    end

    logic [29:0] b2b_adr [4];
    int          lat;
    logic [31:0] rd;
    int          acks;
    int          cnt;

    initial begin
        for (int k = 0; k < 3; k++) idle_bus(k);
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 1024; j++) known_m[k][j] = 1'b0;
        model_reset();
        repeat (3) @(posedge sys_clk);
        #2 sys_rst = 1'b1;

        // Basic write then read, one wait state.
        access(0, 1'b1, 30'h10, 32'hDEADBEEF, 4'hF, lat, rd);
        chk("wr_latency", 0, 32'(lat), 32'd2);
        access(0, 1'b0, 30'h10, 32'h0, 4'hF, lat, rd);
        chk("rd_latency", 0, 32'(lat), 32'd2);
        chk("rd_data", 0, rd, 32'hDEADBEEF);
        @(negedge sys_clk); #1;
        chk("wr_count_1", 0, 32'(wrc_v[0]), 32'd1);
        chk("rd_count_1", 0, 32'(rdc_v[0]), 32'd1);

        // Byte lanes.
        access(0, 1'b1, 30'h3, 32'h11223344, 4'hF, lat, rd);
        access(0, 1'b1, 30'h3, 32'hAABBCCDD, 4'h5, lat, rd);
        access(0, 1'b1, 30'h3, 32'hFFFFFFFF, 4'h0, lat, rd);
        access(0, 1'b0, 30'h3, 32'h0, 4'hF, lat, rd);
        chk("byte_lanes", 0, rd, 32'h11BB33DD);
        @(negedge sys_clk); #1;
        chk("wr_count_sel0", 0, 32'(wrc_v[0]), 32'd4);

        // Abort in the second wait state, three wait states.
        access(1, 1'b1, 30'h7, 32'h000000AA, 4'hF, lat, rd);
        chk("w3_latency", 1, 32'(lat), 32'd4);
        @(posedge sys_clk); #1;
        cyc_v[1] = 1'b1; stb_v[1] = 1'b1; we_v[1] = 1'b1;
        adr_v[1] = 30'h7; datw_v[1] = 32'h55; sel_v[1] = 4'hF;
        @(posedge sys_clk); #1;
        @(posedge sys_clk); #1;
        stb_v[1] = 1'b0;
        cnt = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge sys_clk);
            if (ack_v[1]) cnt++;
        end
        chk("abort_no_ack", 1, 32'(cnt), 32'd0);
        idle_bus(1);
        access(1, 1'b0, 30'h7, 32'h0, 4'hF, lat, rd);
        chk("abort_mem", 1, rd, 32'h000000AA);
        @(negedge sys_clk); #1;
        chk("abort_wrc", 1, 32'(wrc_v[1]), 32'd1);

        // Aliasing, zero wait states.
        access(2, 1'b1, 30'h13, 32'h00001234, 4'hF, lat, rd);
        chk("w0_latency", 2, 32'(lat), 32'd1);
        access(2, 1'b0, 30'h3, 32'h0, 4'hF, lat, rd);
        chk("alias", 2, rd, 32'h00001234);

        // Back-to-back reads under continuous strobe.
        b2b_adr[0] = 30'h3; b2b_adr[1] = 30'h13; b2b_adr[2] = 30'h23; b2b_adr[3] = 30'h3FFFFFF3;
        @(posedge sys_clk); #1;
        cyc_v[2] = 1'b1; stb_v[2] = 1'b1; we_v[2] = 1'b0; sel_v[2] = 4'hF; adr_v[2] = b2b_adr[0];
        acks = 0;
        for (int n = 0; n < 12 && acks < 4; n++) begin
            @(negedge sys_clk);
            if (ack_v[2]) begin
                chk("b2b_spacing", 2, 32'(n), 32'(2 * acks + 1));
                chk("b2b_data", 2, datr_v[2], 32'h00001234);
                acks++;
                @(posedge sys_clk); #1;
                if (acks < 4) adr_v[2] = b2b_adr[acks];
                else idle_bus(2);
            end
        end
        idle_bus(2);
        chk("b2b_acks", 2, 32'(acks), 32'd4);
        @(negedge sys_clk); #1;
        chk("b2b_rdc", 2, 32'(rdc_v[2]), 32'd5);

        // Saturation: preload the read counter near the top, then overrun it.
        @(negedge sys_clk); #2;
        force dut_c.rd_count_r = 16'hFFFD;
        rdc_m[2] = 65533;
        #1 release dut_c.rd_count_r;
        for (int r = 0; r < 4; r++) access(2, 1'b0, 30'h3, 32'h0, 4'hF, lat, rd);
        @(negedge sys_clk); #1;
        chk("saturate", 2, 32'(rdc_v[2]), 32'h0000FFFF);

        // Reset during the ACK cycle of a write.
        @(posedge sys_clk); #1;
        cyc_v[0] = 1'b1; stb_v[0] = 1'b1; we_v[0] = 1'b1;
        adr_v[0] = 30'h10; datw_v[0] = 32'hCAFEF00D; sel_v[0] = 4'hF;
        repeat (3) @(negedge sys_clk);
        chk("pre_rst_ack", 0, 32'(ack_v[0]), 32'h1);
        #1 sys_rst = 1'b0;
        model_reset();
        #1;
        chk("rst_ack_async", 0, 32'(ack_v[0]), 32'h0);
        chk("rst_wrc_async", 0, 32'(wrc_v[0]), 32'h0);
        chk("rst_rdc_async", 2, 32'(rdc_v[2]), 32'h0);
        for (int k = 0; k < 3; k++) idle_bus(k);
        repeat (2) @(posedge sys_clk);
        #2 sys_rst = 1'b1;
        access(0, 1'b0, 30'h10, 32'h0, 4'hF, lat, rd);
        chk("post_rst_latency", 0, 32'(lat), 32'd2);
        chk("post_rst_data", 0, rd, 32'hDEADBEEF);
        @(negedge sys_clk); #1;
        chk("post_rst_rdc", 0, 32'(rdc_v[0]), 32'd1);
        chk("post_rst_wrc", 0, 32'(wrc_v[0]), 32'd0);

        repeat (3) @(posedge sys_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
